// File: rtl/sram_banked_pkg.sv
// sram_banked_pkg: shared types, latency bounds and bank-select helper for sram_banked_mp
package sram_banked_pkg;

    localparam int LatencyMin   = 1;
    localparam int LatencyMax   = 3;
    localparam int DefAddrWidth = 8;
    localparam int DefDataWidth = 32;

    function automatic int bank_sel_w(input int num_banks);
        return num_banks > 1 ? $clog2(num_banks) : 0;
    endfunction

    typedef struct packed {
        logic                    wen;
        logic [DefAddrWidth-1:0] addr;
        logic [DefDataWidth-1:0] wdata;
    } req_t;

    typedef struct packed {
        logic                    rvalid;
        logic [DefDataWidth-1:0] rdata;
        logic                    rerr;
    } rsp_t;

endpackage

// File: rtl/sram_bank.sv
// sram_bank: single-port word array with registered read data and Latency-1 extra output stages (SRAM_PARITY_EN adds a bit-flip port)
module sram_bank #(
    parameter int RowW    = 6,
    parameter int WordW   = 32,
    parameter int Latency = 1
) (
    input  logic             clk,
    input  logic             cs,
    input  logic             wen,
    input  logic [RowW-1:0]  addr,
    input  logic [WordW-1:0] wdata,
`ifdef SRAM_PARITY_EN
    input  logic             inj,
    input  logic [RowW-1:0]  inj_row,
    input  logic [WordW-1:0] inj_mask,
`endif
    output logic [WordW-1:0] rdata
);

    logic [WordW-1:0]              mem [2**RowW];
    logic [Latency-1:0][WordW-1:0] stage;

    // Array access; the first stage only loads on a read, later stages shift every cycle
    always_ff @(posedge clk) begin
        if (cs && wen) mem[addr] <= wdata;
`ifdef SRAM_PARITY_EN
        else if (inj) mem[inj_row] <= mem[inj_row] ^ inj_mask;
`endif
        if (cs && !wen) stage[0] <= mem[addr];
        for (int i = 1; i < Latency; i++) stage[i] <= stage[i-1];
    end

    assign rdata = stage[Latency-1];

endmodule

// File: rtl/sram_banked_mp.sv
// sram_banked_mp: multi-port word-interleaved banked SRAM with per-bank round-robin arbitration (SRAM_PARITY_EN enables stored parity, rerr_o and flip_bit)
module sram_banked_mp
    import sram_banked_pkg::*;
#(
    parameter int NumPorts  = 2,
    parameter int NumBanks  = 4,
    parameter int AddrWidth = 8,
    parameter int DataWidth = 32,
    parameter int Latency   = 1
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NumPorts-1:0]                 req_i,
    output logic [NumPorts-1:0]                 gnt_o,
    input  logic [NumPorts-1:0]                 wen_i,
    input  logic [NumPorts-1:0][AddrWidth-1:0]  addr_i,
    input  logic [NumPorts-1:0][DataWidth-1:0]  wdata_i,
    output logic [NumPorts-1:0]                 rvalid_o,
    output logic [NumPorts-1:0][DataWidth-1:0]  rdata_o,
    output logic [NumPorts-1:0]                 rerr_o
);

    localparam int SelW  = bank_sel_w(NumBanks);
    localparam int RowW  = AddrWidth - SelW;
    localparam int BankW = NumBanks > 1 ? SelW : 1;
    localparam int PortW = NumPorts > 1 ? $clog2(NumPorts) : 1;
`ifdef SRAM_PARITY_EN
    localparam int WordW = DataWidth + 1;
`else
    localparam int WordW = DataWidth;
`endif

    logic [NumPorts-1:0][BankW-1:0]     bank_of;
    logic [NumPorts-1:0][RowW-1:0]      row_of;
    logic [NumPorts-1:0][WordW-1:0]     word_of;
    logic [NumBanks-1:0]                bank_gnt;
    logic [NumBanks-1:0][PortW-1:0]     bank_win;
    logic [NumBanks-1:0]                bank_rv;
    logic [NumBanks-1:0][PortW-1:0]     bank_rid;
    logic [NumBanks-1:0][WordW-1:0]     bank_rdata;
    logic [NumPorts-1:0][DataWidth-1:0] rdata_q;

`ifdef SRAM_PARITY_EN
    logic inj      = 1'b0;
    int   inj_bank = 0;
    int   inj_row  = 0;
    int   inj_bit  = 0;

    task automatic flip_bit(input int bank, input int row, input int bit_idx);
        @(negedge clk_i);
        inj_bank = bank;
        inj_row  = row;
        inj_bit  = bit_idx;
        inj      = 1'b1;
        @(negedge clk_i);
        inj      = 1'b0;
    endtask
`endif

    // Split each port address into bank/row and build the stored word
    always_comb begin
        for (int p = 0; p < NumPorts; p++) begin
            bank_of[p] = BankW'(addr_i[p] & AddrWidth'(NumBanks - 1));
            row_of[p]  = RowW'(addr_i[p] >> SelW);
`ifdef SRAM_PARITY_EN
            word_of[p] = {^wdata_i[p], wdata_i[p]};
`else
            word_of[p] = wdata_i[p];
`endif
        end
    end

    for (genvar b = 0; b < NumBanks; b++) begin : g_bank
        logic [NumPorts-1:0]           hit;
        logic                          gnt;
        logic [PortW-1:0]              win;
        logic [PortW-1:0]              rr_q;
        logic [Latency-1:0]            pv;
        logic [Latency-1:0][PortW-1:0] pid;
        logic [WordW-1:0]              rdata;

        // Requests aimed at this bank; nothing is granted while reset is held
        always_comb begin
            for (int p = 0; p < NumPorts; p++) hit[p] = rst_ni && req_i[p] && bank_of[p] == BankW'(b);
        end

        // First requesting port at or after the round-robin pointer wins
        always_comb begin
            int idx;
            gnt = 1'b0;
            win = '0;
            idx = 0;
            for (int k = 0; k < NumPorts; k++) begin
                idx = int'(rr_q) + k;
                if (idx >= NumPorts) idx -= NumPorts;
                if (!gnt && hit[idx]) begin
                    gnt = 1'b1;
                    win = PortW'(idx);
                end
            end
        end

        // Pointer moves past the winner; idle banks keep their pointer
        always_ff @(posedge clk_i) begin
            if (!rst_ni) rr_q <= '0;
            else if (gnt) rr_q <= win == PortW'(NumPorts - 1) ? '0 : win + 1'b1;
        end

        // Granted-port pipeline that routes read data back after Latency cycles
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                pv  <= '0;
                pid <= '0;
            end else begin
                pv[0]  <= gnt && !wen_i[win];
                pid[0] <= win;
                for (int i = 1; i < Latency; i++) begin
                    pv[i]  <= pv[i-1];
                    pid[i] <= pid[i-1];
                end
            end
        end

        sram_bank #(
            .RowW    (RowW),
            .WordW   (WordW),
            .Latency (Latency)
        ) u_bank (
            .clk      (clk_i),
            .cs       (gnt),
            .wen      (wen_i[win]),
            .addr     (row_of[win]),
            .wdata    (word_of[win]),
`ifdef SRAM_PARITY_EN
            .inj      (inj && inj_bank == b),
            .inj_row  (RowW'(inj_row)),
            .inj_mask (WordW'(1) << inj_bit),
`endif
            .rdata    (rdata)
        );

        assign bank_gnt[b]   = gnt;
        assign bank_win[b]   = win;
        assign bank_rv[b]    = pv[Latency-1];
        assign bank_rid[b]   = pid[Latency-1];
        assign bank_rdata[b] = rdata;
    end

    // Collect per-bank winners into per-port grants
    always_comb begin
        gnt_o = '0;
        for (int b = 0; b < NumBanks; b++)
            if (bank_gnt[b]) gnt_o[bank_win[b]] = 1'b1;
    end

    // Steer returning bank data to the owning port; idle ports show held data
    always_comb begin
        rvalid_o = '0;
        rdata_o  = rdata_q;
        rerr_o   = '0;
        for (int b = 0; b < NumBanks; b++)
            if (bank_rv[b]) begin
                rvalid_o[bank_rid[b]] = 1'b1;
                rdata_o[bank_rid[b]]  = bank_rdata[b][DataWidth-1:0];
`ifdef SRAM_PARITY_EN
                rerr_o[bank_rid[b]]   = ^bank_rdata[b];
`endif
            end
    end

    // Hold register behind rdata_o
    always_ff @(posedge clk_i) begin
        if (!rst_ni) rdata_q <= '0;
        else rdata_q <= rdata_o;
    end

endmodule

// File: doc/sram_banked_mp.md
Name: sram_banked_mp

Overview:
- Multi-port, multi-bank word-interleaved SRAM for FFT twiddle and data buffers.
- Up to NumPorts requesters share NumBanks single-port banks.
- A per-bank round-robin arbiter resolves conflicts with a req/gnt handshake.
- Read data returns after a parametrised latency with a valid strobe. This supersedes the single-bank, fixed-port SRAM wrapper for butterfly stages that need parallel access.

Parameters:
- NumPorts, 2, number of requester ports (>=1).
- NumBanks, 4, number of banks; power of 2, >=1.
- AddrWidth, 8, word address width per port; must exceed log2(NumBanks).
- DataWidth, 32, data word width.
- Latency, 1, read latency in cycles from grant to rvalid_o; legal values 1..3.

Ports:
- clk_i  input  1  clock (single clock domain).
- rst_ni  input  1  synchronous active-low reset.
- req_i  input  NumPorts  request per port.
- gnt_o  output  NumPorts  grant per port; same-cycle combinational from req_i/addr_i.
- wen_i  input  NumPorts  1 = write, 0 = read.
- addr_i  input  NumPorts x AddrWidth  word address.
- wdata_i  input  NumPorts x DataWidth  write data.
- rvalid_o  output  NumPorts  read data valid.
- rdata_o  output  NumPorts x DataWidth  read data.
- rerr_o  output  NumPorts  parity error on the returned read (see Optional Feature).

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_ni is synchronous and active-low.
- Bank mapping: bank = addr_i[log2(NumBanks)-1:0]; row = addr_i[AddrWidth-1:log2(NumBanks)]. NumBanks=1 means bank 0 and row = the full address.
- Handshake:
  - A port holds req_i, wen_i, addr_i and wdata_i stable until gnt_o is high; the transfer completes in the cycle where req_i && gnt_o.
  - gnt_o is never high without req_i.
- Arbitration:
  - Each bank grants at most one port per cycle.
  - Ports targeting different banks are all granted in the same cycle.
  - On a conflict, the winner is the first requesting port at or after that bank's pointer rr_q[b], searching cyclically.
  - On any grant in bank b, rr_q[b] <= winner+1 mod NumPorts. A bank with no grant keeps its pointer.
- Write: data is stored at the clock edge of the grant cycle. A read of the same address granted in any later cycle returns the new data.
- Read:
  - Grant at cycle t gives rvalid_o[p]=1 for exactly one cycle at t+Latency, with rdata_o[p] valid in that cycle.
  - Reads are fully pipelined: one read per port per cycle.
  - rdata_o holds its last value while rvalid_o is low.
  - Writes never raise rvalid_o.
- Same-cycle read and write to the same bank from different ports: serialised by arbitration, with no bypass.
- Reset (rst_ni=0 at an edge):
  - rr_q all 0; rvalid_o, rdata_o and rerr_o all 0.
  - The Latency pipeline valid bits are cleared, so in-flight reads are dropped and produce no rvalid.
  - gnt_o is forced 0 while rst_ni=0, so no write commits.
  - Array contents are not reset (simulation initialises them to zero).
- Empty cycle (no req_i): no state change except the read pipeline advances.

Optional Feature:
- Macro: SRAM_PARITY_EN.
- Enabled:
  - Each bank word stores DataWidth+1 bits, the extra bit being even parity of the written data.
  - On read return, rerr_o[p]=1 in the rvalid cycle if the stored parity mismatches; data is returned unmodified.
  - Simulation-only task flip_bit(bank,row,bit) allows error injection.
- Disabled: banks are DataWidth wide and rerr_o is tied to 0.

Decomposition:
- Package sram_banked_pkg:
  - BankSelW = $clog2(NumBanks) helper function.
  - Typedefs: req_t {wen, addr, wdata} and rsp_t {rvalid, rdata, rerr}.
  - Latency min/max constants.
- One sub-module, sram_bank: a single-port array of depth 2^(AddrWidth-BankSelW).
  - Interface: cs/wen/addr/wdata; rdata is registered.
  - Contains the Latency-1 extra output register stages.
- Arbiter and rr pointers live in the top block, generated per bank. The return path is routed by a per-bank pipeline of granted-port IDs.

Test Plan:
- No conflict, NumBanks=4, Latency=2: write 0xA5A5_0001 to port0 addr 0x04 and port1 addr 0x05 in one cycle -> both gnt=1. Read them back next cycle -> rvalid on both ports exactly 2 cycles later with the same data.
- Conflict: both ports read bank 0 (addr 0x00, 0x08) for 4 cycles, rr_q[0]=0 -> grants alternate p0,p1,p0,p1. Each port receives its data Latency cycles after each grant.
- Read after write: port0 writes 0x1234 to 0x10 at t, port1 reads 0x10 at t+1 -> rdata_o[1]=0x1234.
- Reset mid-flight: Latency=3, a read granted at t, rst_ni=0 at t+1 -> no rvalid at t+3; rr_q=0 and all outputs 0 after reset.
- Back-to-back streaming: port0 reads addr 0..15 every cycle with no contention -> 16 consecutive rvalid pulses in address order.
- With SRAM_PARITY_EN: write 0xFF to addr 0x02, flip bit 3, read -> rdata=0xF7 and rerr_o=1. Unflipped reads -> rerr_o=0.
